ad9226_acq_ctrl: RTL
====================

# ad9226_acq_ctrl

Acquisition controller and stream scheduler for the four-channel AD9226 capture path. Generates the sample clock and ready enable that drive the capture block. Detects each end-of-conversion, buffers the four channel words, and serialises them round-robin onto one AXI-Stream master with frame framing (tlast) and overflow reporting. Sits between the register/control layer and the DMA-facing stream.

## Interface

Parameters:
- ADC_DATA_WIDTH, 12, sample width from the capture block.
- CLK_DIV, 10, clk cycles per sample period. Must be even and ≥ 8.
- FRAME_LEN, 256, sample sets (4 beats each) per frame. Must be ≥ 1.
- TDATA_WIDTH, 16, stream width. Must be ≥ ADC_DATA_WIDTH+2.

Ports (clock and reset first):
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins acquisition; ignored unless idle.
- stop  in  1  one-cycle pulse; requests halt at the next frame boundary.
- adc_clk_sample  out  1  sample clock to the capture block.
- adc_ready  out  1  capture enable; high while running.
- adc_eoc  in  1  end-of-conversion level from the capture block.
- adc_data0..adc_data3  in  ADC_DATA_WIDTH each  captured channel words.
- m_axis_tdata  out  TDATA_WIDTH  {ch_id[1:0], zero pad, sample}.
- m_axis_tvalid  out  1  AXI-Stream valid.
- m_axis_tready  in  1  AXI-Stream ready.
- m_axis_tlast  out  1  high on the final beat of a frame.
- busy  out  1  high in any state other than IDLE.
- overflow  out  1  sticky; a sample set was dropped.
- frame_done  out  1  one-cycle pulse when a tlast beat is accepted.

## Operation

- FSM states:
  - IDLE
    - start → RUN. The same edge clears overflow, the divider, the set counter and stop_pend.
  - RUN
    - Divider runs.
    - On an eoc rising edge (adc_eoc=1 and the registered prior value=0), latch adc_data0..3 into the buffer, set buf_full, then → SEND.
  - SEND
    - Emits beats for ch0, ch1, ch2, ch3 in order. A beat advances only on tvalid&&tready.
    - After the ch3 beat is accepted, clear buf_full and return to RUN.
    - If that beat was tlast and stop_pend=1, go to IDLE instead.
- The divider keeps running in SEND.
- stop_pend:
  - Set by stop in RUN or SEND.
  - Cleared on entry to IDLE.
  - stop in IDLE has no effect.
- Sample clock:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - adc_clk_sample = (div_cnt < CLK_DIV/2) while busy; 1 in IDLE.
  - adc_ready = busy.
- Beat format:
  - tdata[TDATA_WIDTH-1:TDATA_WIDTH-2] = channel index.
  - Low ADC_DATA_WIDTH bits = sample.
  - All bits in between = 0.
- Framing:
  - set_cnt counts accepted sets 0..FRAME_LEN-1.
  - tlast=1 only on the ch3 beat when set_cnt = FRAME_LEN-1.
  - set_cnt increments (wraps to 0) when a ch3 beat is accepted.
- Overflow:
  - An eoc rising edge while buf_full=1 drops the new set (buffer unchanged, set_cnt unchanged) and sets overflow.
  - Exception: if the edge coincides with acceptance of the ch3 beat, the set is latched, not dropped. The FSM goes directly back to SEND at ch0, or to IDLE if the stop rule applies; in that case the set is discarded silently without setting overflow.
- tdata/tvalid/tlast stay stable while tvalid=1 and tready=0.
- Reset, at any time, asynchronously forces:
  - IDLE state; buffer cleared.
  - adc_clk_sample=1, adc_ready=0.
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0.
  - busy=0, overflow=0, frame_done=0.
  - An in-flight frame is abandoned, with no tlast.

## Timing

- start at edge N → busy=1, adc_ready=1 after edge N. div_cnt=0 at N+1, so adc_clk_sample is high for CLK_DIV/2 cycles, then low for CLK_DIV/2 cycles.
- eoc rising edge sampled at edge E → m_axis_tvalid=1 with the ch0 beat after edge E (1-cycle latency).
- With tready held at 1: 4 consecutive beats; tvalid drops after the ch3 beat unless a new set is latched the same cycle.
- frame_done asserts the cycle after tlast acceptance, for exactly one cycle.
- busy drops on the edge that accepts the final tlast beat when stop_pend=1.
- Outputs are registered; there is no combinational path from tready to tvalid or tdata.

## Test plan

- Basic frame:
  - Stimulus: CLK_DIV=10, FRAME_LEN=2, tready=1, data0..3 = 0x111/0x222/0x333/0x444, start, 2 eoc pulses.
  - Required: 8 beats 0x0111, 0x4222, 0x8333, 0xC444 repeated; tlast only on beat 8; frame_done once; adc_clk_sample period 10 cycles, 50% duty.
- Backpressure:
  - Stimulus: tready held 0 for 6 cycles mid-set.
  - Required: tdata/tvalid/tlast stable throughout; no beat lost or duplicated.
- Overflow:
  - Stimulus: tready=0, a second eoc edge arrives while buf_full=1.
  - Required: overflow=1; after release, only the first set's 4 beats appear; set_cnt not advanced.
- Coincident edge:
  - Stimulus: eoc edge in the same cycle the ch3 beat is accepted.
  - Required: overflow stays 0; the next ch0 beat carries the new data.
- Stop:
  - Stimulus: stop mid-frame with FRAME_LEN=4.
  - Required: the frame completes with tlast; busy=0; adc_clk_sample=1; adc_ready=0; further eoc edges are ignored.
- Async reset:
  - Stimulus: rst_n low during the ch1 beat.
  - Required: all outputs at their reset values immediately, without waiting for a clock edge; a subsequent start begins a fresh frame at ch0 with set_cnt=0.

Source files
------------

// File: rtl/ad9226_acq_ctrl.sv
// AD9226 acquisition controller. It generates the sample clock and capture enable, latches the
// four channel words on each end-of-conversion, and streams them round-robin with frame tlast.

module ad9226_acq_ctrl #(
  parameter int ADC_DATA_WIDTH = 12,
  parameter int CLK_DIV        = 10,
  parameter int FRAME_LEN      = 256,
  parameter int TDATA_WIDTH    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      stop,
  output logic                      adc_clk_sample,
  output logic                      adc_ready,
  input  logic                      adc_eoc,
  input  logic [ADC_DATA_WIDTH-1:0] adc_data0,
  input  logic [ADC_DATA_WIDTH-1:0] adc_data1,
  input  logic [ADC_DATA_WIDTH-1:0] adc_data2,
  input  logic [ADC_DATA_WIDTH-1:0] adc_data3,
  output logic [TDATA_WIDTH-1:0]    m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      m_axis_tlast,
  output logic                      busy,
  output logic                      overflow,
  output logic                      frame_done
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int SET_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t                         state;
  logic                           eoc_q;
  logic [3:0][ADC_DATA_WIDTH-1:0] buf_data;
  logic                           buf_full;
  logic [1:0]                     ch_idx;
  logic [DIV_W-1:0]               div_cnt;
  logic [SET_W-1:0]               set_cnt;
  logic                           stop_pend;

  logic             eoc_rise;
  logic             accept;
  logic             ch3_acc;
  logic             halt;
  logic             latch_set;
  logic [DIV_W-1:0] div_nxt;
  logic [1:0]       ch_nxt;
  logic [SET_W-1:0] set_nxt;

  assign eoc_rise  = adc_eoc & ~eoc_q;
  assign accept    = m_axis_tvalid & m_axis_tready;
  assign ch3_acc   = (state == SEND) && accept && (ch_idx == 2'd3);
  assign halt      = ch3_acc && m_axis_tlast && stop_pend;
  // A set arriving on the same edge that frees the buffer is taken, unless we are halting.
  assign latch_set = eoc_rise && ((state == RUN) || (ch3_acc && !halt));
  assign div_nxt   = (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
  assign ch_nxt    = ch_idx + 2'd1;
  assign set_nxt   = (set_cnt == SET_LAST) ? '0 : set_cnt + SET_W'(1);
  assign adc_ready = busy;

  function automatic logic [TDATA_WIDTH-1:0] fmt_beat(input logic [1:0] ch,
                                                      input logic [ADC_DATA_WIDTH-1:0] s);
    logic [TDATA_WIDTH-1:0] b;
    b = '0;
    b[ADC_DATA_WIDTH-1:0] = s;
    b[TDATA_WIDTH-1 -: 2] = ch;
    return b;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_data <= '0;
    end else if (latch_set) begin
      buf_data <= {adc_data3, adc_data2, adc_data1, adc_data0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      eoc_q          <= 1'b0;
      buf_full       <= 1'b0;
      ch_idx         <= 2'd0;
      div_cnt        <= '0;
      set_cnt        <= '0;
      stop_pend      <= 1'b0;
      adc_clk_sample <= 1'b1;
      busy           <= 1'b0;
      overflow       <= 1'b0;
      frame_done     <= 1'b0;
      m_axis_tdata   <= '0;
      m_axis_tvalid  <= 1'b0;
      m_axis_tlast   <= 1'b0;
    end else begin
      eoc_q      <= adc_eoc;
      frame_done <= 1'b0;

      if (eoc_rise && buf_full && !ch3_acc) begin
        overflow <= 1'b1;
      end

      if (latch_set) begin
        buf_full      <= 1'b1;
        ch_idx        <= 2'd0;
        m_axis_tdata  <= fmt_beat(2'd0, adc_data0);
        m_axis_tvalid <= 1'b1;
        m_axis_tlast  <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state          <= RUN;
            busy           <= 1'b1;
            overflow       <= 1'b0;
            div_cnt        <= '0;
            adc_clk_sample <= 1'b1;
            set_cnt        <= '0;
            stop_pend      <= 1'b0;
          end
        end

        RUN: begin
          div_cnt        <= div_nxt;
          adc_clk_sample <= (div_nxt < DIV_HALF);
          if (stop) begin
            stop_pend <= 1'b1;
          end
          if (latch_set) begin
            state <= SEND;
          end
        end

        SEND: begin
          div_cnt        <= div_nxt;
          adc_clk_sample <= (div_nxt < DIV_HALF);
          if (stop) begin
            stop_pend <= 1'b1;
          end
          if (accept && (ch_idx != 2'd3)) begin
            ch_idx       <= ch_nxt;
            m_axis_tdata <= fmt_beat(ch_nxt, buf_data[ch_nxt]);
            m_axis_tlast <= (ch_nxt == 2'd3) && (set_cnt == SET_LAST);
          end else if (ch3_acc) begin
            set_cnt    <= set_nxt;
            frame_done <= m_axis_tlast;
            if (halt) begin
              state          <= IDLE;
              busy           <= 1'b0;
              stop_pend      <= 1'b0;
              buf_full       <= 1'b0;
              div_cnt        <= '0;
              adc_clk_sample <= 1'b1;
              m_axis_tvalid  <= 1'b0;
              m_axis_tlast   <= 1'b0;
            end else if (!latch_set) begin
              state         <= RUN;
              buf_full      <= 1'b0;
              m_axis_tvalid <= 1'b0;
              m_axis_tlast  <= 1'b0;
            end
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
